// File: rtl/sorter_drain_scheduler_pkg.sv
// rtl/sorter_drain_scheduler_pkg.sv - shared sorter constants, state and source encodings
package sorter_pkg;

    // Drain FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_OUTPUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_READ    = ST_READ,
        S_CAPTURE = ST_CAPTURE,
        S_OUTPUT  = ST_OUTPUT
    } drain_state_t;

    // Source of a drained word
    localparam logic SRC_VAL  = 1'b0;
    localparam logic SRC_IVAL = 1'b1;

    // Write-response codes used across the sorter register blocks
    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_t;

    // Marker byte that opens a valid packet
    localparam logic [7:0] VALID_MARKER = 8'hA5;

endpackage

// File: rtl/sorter_drain_scheduler_if.sv
// rtl/sorter_drain_scheduler_if.sv - downstream drained-byte stream with valid/ready handshake
// Signals: out_valid/out_data/out_src driven by the scheduler (master),
//          out_ready driven by the consumer (slave).
interface sorter_drain_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport master (output out_valid, output out_data, output out_src, input out_ready);
    modport slave  (input out_valid, input out_data, input out_src, output out_ready);
endinterface

// File: rtl/drain_grant_arb.sv
// rtl/drain_grant_arb.sv - weighted round-robin grant with invalid-queue urgency override
// Ports: clk, rst (async high); val_empty/val_level, ival_empty/ival_level FIFO status;
//        grant_take pulses when the FSM accepts the grant; grant_sel (0 valid, 1 invalid);
//        any_ready high when at least one queue holds data.
module drain_grant_arb
    import sorter_pkg::*;
#(
    parameter int LVL_W       = 4,
    parameter int VAL_WEIGHT  = 3,
    parameter int IVAL_URGENT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             val_empty,
    input  logic [LVL_W-1:0] val_level,
    input  logic             ival_empty,
    input  logic [LVL_W-1:0] ival_level,
    input  logic             grant_take,
    output logic             grant_sel,
    output logic             any_ready
);
    logic [3:0] wcnt_q, wcnt_d;
    logic       val_avail, ival_avail, urgent;

    // A queue counts as holding data only when flag and level agree,
    // so a momentary flag/level skew in the FIFO never yields a read of nothing.
    assign val_avail  = !val_empty  && (val_level  != '0);
    assign ival_avail = !ival_empty && (ival_level != '0);
    assign urgent     = ival_avail && (ival_level >= LVL_W'(IVAL_URGENT));
    assign any_ready  = val_avail || ival_avail;

    always_comb begin
        grant_sel = SRC_VAL;
        if (urgent) begin
            grant_sel = SRC_IVAL;
        end else if (val_avail && ival_avail) begin
            grant_sel = (wcnt_q < 4'(VAL_WEIGHT)) ? SRC_VAL : SRC_IVAL;
        end else if (!val_avail) begin
            grant_sel = SRC_IVAL;
        end
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (grant_take) begin
            if (grant_sel == SRC_IVAL) begin
                wcnt_d = 4'd0;
            end else if (wcnt_q < 4'(VAL_WEIGHT)) begin
                wcnt_d = wcnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= 4'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
endmodule

// File: rtl/sorter_drain_scheduler.sv
// rtl/sorter_drain_scheduler.sv - drains valid/invalid FIFOs onto one downstream stream
// Ports: clk, rst (async high); enable; val_*/ival_* FIFO read side (empty, level, rdata, rd_en);
//        dn downstream stream (out_valid/out_data/out_src/out_ready); busy;
//        val_drained/ival_drained per-queue delivered-word counters.
module sorter_drain_scheduler
    import sorter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 10,
    parameter int LVL_W       = 4,
    parameter int VAL_WEIGHT  = 3,
    parameter int IVAL_URGENT = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        val_empty,
    input  logic [LVL_W-1:0]            val_level,
    input  logic [WIDTH-1:0]            val_rdata,
    input  logic                        ival_empty,
    input  logic [LVL_W-1:0]            ival_level,
    input  logic [WIDTH-1:0]            ival_rdata,
    output logic                        val_rd_en,
    output logic                        ival_rd_en,
    sorter_drain_scheduler_if.master    dn,
    output logic                        busy,
    output logic [15:0]                 val_drained,
    output logic [15:0]                 ival_drained
);
    // The urgency threshold can never exceed what the FIFO can hold.
    localparam int URGENT_EFF = (IVAL_URGENT > DEPTH) ? DEPTH : IVAL_URGENT;

    drain_state_t     state_q, state_d;
    logic             sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic [15:0]      val_cnt_q, val_cnt_d;
    logic [15:0]      ival_cnt_q, ival_cnt_d;
    logic             grant_take, grant_sel, any_ready;

    drain_grant_arb #(
        .LVL_W       (LVL_W),
        .VAL_WEIGHT  (VAL_WEIGHT),
        .IVAL_URGENT (URGENT_EFF)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .val_empty  (val_empty),
        .val_level  (val_level),
        .ival_empty (ival_empty),
        .ival_level (ival_level),
        .grant_take (grant_take),
        .grant_sel  (grant_sel),
        .any_ready  (any_ready)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        val_cnt_d   = val_cnt_q;
        ival_cnt_d  = ival_cnt_q;
        grant_take  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && any_ready) begin
                    grant_take = 1'b1;
                    sel_d      = grant_sel;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // FIFO data is valid now, one cycle after the read strobe.
                out_data_d  = (sel_q == SRC_IVAL) ? ival_rdata : val_rdata;
                out_src_d   = sel_q;
                out_valid_d = 1'b1;
                state_d     = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (dn.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_src_q == SRC_IVAL) begin
                        ival_cnt_d = ival_cnt_q + 16'd1;
                    end else begin
                        val_cnt_d = val_cnt_q + 16'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= SRC_VAL;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_VAL;
            val_cnt_q   <= 16'd0;
            ival_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            val_cnt_q   <= val_cnt_d;
            ival_cnt_q  <= ival_cnt_d;
        end
    end

    // Read strobes are a pure decode of READ, so they last exactly one cycle.
    assign val_rd_en    = (state_q == S_READ) && (sel_q == SRC_VAL);
    assign ival_rd_en   = (state_q == S_READ) && (sel_q == SRC_IVAL);
    assign busy         = (state_q != S_IDLE);
    assign dn.out_valid = out_valid_q;
    assign dn.out_data  = out_data_q;
    assign dn.out_src   = out_src_q;
    assign val_drained  = val_cnt_q;
    assign ival_drained = ival_cnt_q;
endmodule

// File: tb/tb_sorter_drain_scheduler.sv
// tb/tb_sorter_drain_scheduler.sv - self-checking bench for sorter_drain_scheduler
module tb_sorter_drain_scheduler;
    localparam int WIDTH       = 8;
    localparam int DEPTH       = 10;
    localparam int LVL_W       = 4;
    localparam int VAL_WEIGHT  = 3;
    localparam int IVAL_URGENT = 8;

    logic             clk, rst, enable;
    logic             val_empty, ival_empty;
    logic [LVL_W-1:0] val_level, ival_level;
    logic [WIDTH-1:0] val_rdata, ival_rdata;
    logic             val_rd_en, ival_rd_en, busy;
    logic [15:0]      val_drained, ival_drained;

    sorter_drain_scheduler_if #(.WIDTH(WIDTH)) dn ();

    sorter_drain_scheduler #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W),
        .VAL_WEIGHT(VAL_WEIGHT), .IVAL_URGENT(IVAL_URGENT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .val_empty(val_empty), .val_level(val_level), .val_rdata(val_rdata),
        .ival_empty(ival_empty), .ival_level(ival_level), .ival_rdata(ival_rdata),
        .val_rd_en(val_rd_en), .ival_rd_en(ival_rd_en),
        .dn(dn), .busy(busy),
        .val_drained(val_drained), .ival_drained(ival_drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO contents seen by the DUT
    logic [7:0] vq[$];
    logic [7:0] iq[$];
    // Reference model: queue contents, weight counter, expected output stream, counters
    logic [7:0] mvq[$];
    logic [7:0] miq[$];
    logic       exp_src[$];
    logic [7:0] exp_data[$];
    int         mwcnt;
    int         m_val, m_ival;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_levels();
        val_level  = LVL_W'(vq.size());
        ival_level = LVL_W'(iq.size());
        val_empty  = (vq.size() == 0);
        ival_empty = (iq.size() == 0);
    endtask

    // One clock: check read-strobe legality, advance, then model the FIFO's one-cycle read latency.
    task automatic step();
        logic vr, ir;
        vr = val_rd_en;
        ir = ival_rd_en;
        check("rd_en_exclusive", {31'b0, vr & ir}, 32'd0);
        if (vr) check("val_rd_nonempty", {31'b0, vq.size() > 0}, 32'd1);
        if (ir) check("ival_rd_nonempty", {31'b0, iq.size() > 0}, 32'd1);
        @(posedge clk);
        #1;
        if (vr && vq.size() > 0) val_rdata = vq.pop_front();
        if (ir && iq.size() > 0) ival_rdata = iq.pop_front();
        update_levels();
    endtask

    task automatic fill(input int nv, input int ni);
        logic [7:0] b;
        for (int k = 0; k < nv; k++) begin
            b = 8'($urandom);
            vq.push_back(b);
            mvq.push_back(b);
        end
        for (int k = 0; k < ni; k++) begin
            b = 8'($urandom);
            iq.push_back(b);
            miq.push_back(b);
        end
        update_levels();
    endtask

    // Grant rules applied to queue occupancies, appending the expected word.
    function automatic void model_grant();
        bit s;
        if (mvq.size() == 0 && miq.size() == 0) return;
        if (miq.size() >= IVAL_URGENT) s = 1'b1;
        else if (mvq.size() > 0 && miq.size() > 0) s = (mwcnt >= VAL_WEIGHT);
        else s = (mvq.size() == 0);
        exp_src.push_back(s);
        if (s) begin
            exp_data.push_back(miq.pop_front());
            mwcnt = 0;
        end else begin
            exp_data.push_back(mvq.pop_front());
            if (mwcnt < VAL_WEIGHT) mwcnt++;
        end
    endfunction

    function automatic void model_plan_all();
        while (mvq.size() + miq.size() > 0) model_grant();
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        dn.out_ready = 1'b0;
        vq.delete(); iq.delete(); mvq.delete(); miq.delete();
        exp_src.delete(); exp_data.delete();
        mwcnt = 0; m_val = 0; m_ival = 0;
        val_rdata = '0; ival_rdata = '0;
        update_levels();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Drain n words, comparing each handshake with the model's expected stream.
    task automatic run_words(input int n, input bit rnd_ready, output int cycles);
        int got = 0;
        bit hs, s;
        logic [7:0] d;
        cycles = 0;
        while (got < n && cycles < 50 * n + 50) begin
            dn.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            hs = dn.out_valid && dn.out_ready;
            if (hs) begin
                if (exp_src.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    s = exp_src.pop_front();
                    d = exp_data.pop_front();
                    check("out_src", {31'b0, dn.out_src}, {31'b0, s});
                    check("out_data", {24'b0, dn.out_data}, {24'b0, d});
                    if (s) m_ival++; else m_val++;
                end
                got++;
            end
            step();
            cycles++;
            if (hs) begin
                check("val_drained", {16'b0, val_drained}, 32'(m_val & 16'hFFFF));
                check("ival_drained", {16'b0, ival_drained}, 32'(m_ival & 16'hFFFF));
            end
        end
        check("drain_timeout", 32'(got), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_val_rd_en"}, {31'b0, val_rd_en}, 32'd0);
        check({tag, "_ival_rd_en"}, {31'b0, ival_rd_en}, 32'd0);
        check({tag, "_out_valid"}, {31'b0, dn.out_valid}, 32'd0);
        check({tag, "_out_data"}, {24'b0, dn.out_data}, 32'd0);
        check({tag, "_out_src"}, {31'b0, dn.out_src}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_val_drained"}, {16'b0, val_drained}, 32'd0);
        check({tag, "_ival_drained"}, {16'b0, ival_drained}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, total;
        logic [7:0] held;

        // 1. Reset values, then single invalid word with cycle-exact timing
        do_reset();
        check_all_zero("reset");
        iq.push_back(8'h3C);
        update_levels();
        enable = 1'b1;
        dn.out_ready = 1'b1;
        step();
        check("t1_ival_rd_en_c2", {31'b0, ival_rd_en}, 32'd1);
        check("t1_val_rd_en_c2", {31'b0, val_rd_en}, 32'd0);
        check("t1_busy_c2", {31'b0, busy}, 32'd1);
        step();
        check("t1_ival_rd_en_c3", {31'b0, ival_rd_en}, 32'd0);
        check("t1_out_valid_c3", {31'b0, dn.out_valid}, 32'd0);
        step();
        check("t1_out_valid_c4", {31'b0, dn.out_valid}, 32'd1);
        check("t1_out_data_c4", {24'b0, dn.out_data}, 32'h3C);
        check("t1_out_src_c4", {31'b0, dn.out_src}, 32'd1);
        step();
        check("t1_ival_drained", {16'b0, ival_drained}, 32'd1);
        check("t1_out_valid_done", {31'b0, dn.out_valid}, 32'd0);
        check("t1_busy_done", {31'b0, busy}, 32'd0);

        // 2. Weighted round-robin, 4 cycles per word with out_ready high
        do_reset();
        fill(6, 6);
        model_plan_all();
        enable = 1'b1;
        run_words(8, 1'b0, cyc);
        check("t2_val_after8", {16'b0, val_drained}, 32'd6);
        check("t2_ival_after8", {16'b0, ival_drained}, 32'd2);
        check("t2_cycles_8words", 32'(cyc), 32'd32);
        run_words(4, 1'b0, cyc);

        // 3. Urgency override at ival_level == IVAL_URGENT with wcnt 0
        do_reset();
        fill(3, IVAL_URGENT);
        model_plan_all();
        enable = 1'b1;
        run_words(1, 1'b0, cyc);
        check("t3_urgent_ival", {16'b0, ival_drained}, 32'd1);
        check("t3_urgent_val", {16'b0, val_drained}, 32'd0);
        run_words(IVAL_URGENT + 2, 1'b0, cyc);

        // 4. Backpressure: output stable, no reads, then exactly one counter moves
        do_reset();
        fill(1, 1);
        model_plan_all();
        enable = 1'b1;
        step(); step(); step();
        check("t4_out_valid", {31'b0, dn.out_valid}, 32'd1);
        held = dn.out_data;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t4_stable_data", {24'b0, dn.out_data}, {24'b0, held});
            check("t4_stall_valid", {31'b0, dn.out_valid}, 32'd1);
            check("t4_no_rd", {30'b0, val_rd_en, ival_rd_en}, 32'd0);
        end
        check("t4_no_count", {val_drained, ival_drained}, 32'd0);
        run_words(1, 1'b0, cyc);
        check("t4_one_counter", 32'(val_drained) + 32'(ival_drained), 32'd1);
        run_words(1, 1'b0, cyc);

        // 5. enable dropped during READ: word completes, nothing new starts
        do_reset();
        fill(3, 3);
        enable = 1'b1;
        dn.out_ready = 1'b1;
        step();
        check("t5_busy_read", {31'b0, busy}, 32'd1);
        enable = 1'b0;
        model_grant();
        run_words(1, 1'b0, cyc);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t5_idle_busy", {31'b0, busy}, 32'd0);
            check("t5_idle_no_rd", {30'b0, val_rd_en, ival_rd_en}, 32'd0);
        end

        // 6. Asynchronous reset in CAPTURE
        do_reset();
        fill(4, 0);
        model_plan_all();
        enable = 1'b1;
        run_words(2, 1'b0, cyc);
        step();
        step();
        check("t6_busy_capture", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        step();
        rst = 1'b0;
        mvq = vq;
        miq = iq;
        exp_src.delete(); exp_data.delete();
        mwcnt = 0; m_val = 0; m_ival = 0;
        check("t6_busy_after", {31'b0, busy}, 32'd0);
        check("t6_counters_after", {val_drained, ival_drained}, 32'd0);
        model_plan_all();
        run_words(1, 1'b0, cyc);
        check("t6_restart_val", {16'b0, val_drained}, 32'd1);
        run_words(exp_src.size(), 1'b0, cyc);

        // Randomized rounds: random occupancies and random backpressure, weight carried across rounds
        do_reset();
        enable = 1'b1;
        for (int r = 0; r < 8; r++) begin
            fill($urandom_range(0, DEPTH), $urandom_range(0, DEPTH));
            total = mvq.size() + miq.size();
            model_plan_all();
            run_words(total, 1'b1, cyc);
            check("rnd_all_delivered", 32'(exp_src.size()), 32'd0);
            check("rnd_fifos_empty", 32'(vq.size() + iq.size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
